// File: rtl/vec_wb_pkg.sv
// rtl/vec_wb_pkg.sv - shared types and helpers for the vector bitwise writeback stage
//
// Contents:
//   WB_VLEN       vector register width in bits (taken from MAX_VLEN, default 512)
//   elem_class_e  per-element classification used by the merge logic
//   wb_entry_t    one queued writeback entry {data, be, addr}
//   sew_bytes()   element width in bytes for a 2-bit SEW code
`ifndef MAX_VLEN
`define MAX_VLEN 512
`endif

package vec_wb_pkg;

    localparam int WB_VLEN = `MAX_VLEN;

    typedef enum logic [1:0] {
        PRESTART    = 2'd0,
        BODY_ACTIVE = 2'd1,
        MASKED_OFF  = 2'd2,
        TAIL        = 2'd3
    } elem_class_e;

    typedef struct packed {
        logic [WB_VLEN-1:0]   data;
        logic [WB_VLEN/8-1:0] be;
        logic [4:0]           addr;
    } wb_entry_t;

    function automatic logic [3:0] sew_bytes(input logic [1:0] sew);
        return 4'd1 << sew;
    endfunction

endpackage

// File: rtl/vec_wb_merge.sv
// rtl/vec_wb_merge.sv - combinational element classification, data merge and byte enables
//
// Optional feature macro: VEC_WB_AGNOSTIC_ONES_EN (agnostic tail/masked bytes written as all-ones)
//
// Ports:
//   bw_result    in   VLEN     new result from the bitwise unit
//   old_vd       in   VLEN     prior destination contents
//   v0_mask      in   VLEN/8   mask bit per element index
//   vm           in   1        1 = unmasked operation
//   vta, vma     in   1        tail / mask agnostic policy
//   sew          in   2        element width code (8 << sew bits)
//   vl, vstart   in   VL_W     active length, start index
//   merged_data  out  VLEN     merged write data
//   merged_be    out  VLEN/8   byte enables
module vec_wb_merge
    import vec_wb_pkg::*;
#(
    parameter int VLEN = `MAX_VLEN,
    parameter int VL_W = $clog2(VLEN/8) + 1
) (
    input  logic [VLEN-1:0]   bw_result,
    input  logic [VLEN-1:0]   old_vd,
    input  logic [VLEN/8-1:0] v0_mask,
    input  logic              vm,
    input  logic              vta,
    input  logic              vma,
    input  logic [1:0]        sew,
    input  logic [VL_W-1:0]   vl,
    input  logic [VL_W-1:0]   vstart,
    output logic [VLEN-1:0]   merged_data,
    output logic [VLEN/8-1:0] merged_be
);

    localparam int NB = VLEN / 8;

    logic [VL_W-1:0] vlmax;
    logic [VL_W-1:0] vl_eff;
    logic [VL_W-1:0] elem;
    elem_class_e     cls;

`ifndef VEC_WB_AGNOSTIC_ONES_EN
    // Policy bits only matter when agnostic elements are overwritten.
    logic unused_policy;
    assign unused_policy = vta ^ vma;
`endif

    always_comb begin
        merged_data = old_vd;
        merged_be   = '0;
        elem        = '0;
        cls         = PRESTART;
        vlmax       = VL_W'(NB >> sew);
        // vl beyond VLMAX behaves as VLMAX
        vl_eff      = (vl > vlmax) ? vlmax : vl;
        for (int b = 0; b < NB; b++) begin
            // byte b belongs to element b / (1 << sew)
            elem = VL_W'(b >> sew);
            if (elem < vstart)
                cls = PRESTART;
            else if (elem >= vl_eff)
                cls = TAIL;
            else if (!vm && !v0_mask[elem[VL_W-2:0]])
                cls = MASKED_OFF;
            else
                cls = BODY_ACTIVE;

            unique case (cls)
                BODY_ACTIVE: begin
                    merged_data[8*b +: 8] = bw_result[8*b +: 8];
                    merged_be[b]          = 1'b1;
                end
`ifdef VEC_WB_AGNOSTIC_ONES_EN
                TAIL: begin
                    if (vta) begin
                        merged_data[8*b +: 8] = 8'hFF;
                        merged_be[b]          = 1'b1;
                    end
                end
                MASKED_OFF: begin
                    if (vma) begin
                        merged_data[8*b +: 8] = 8'hFF;
                        merged_be[b]          = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/vector_bitwise_wb_stage.sv
// rtl/vector_bitwise_wb_stage.sv - writeback stage: merge, byte enables, 2-entry skid FIFO to VRF
//
// Optional feature macro: VEC_WB_AGNOSTIC_ONES_EN (passed through to vec_wb_merge)
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   upstream handshake (ready while FIFO not full)
//   bw_result, old_vd     new result and prior destination contents
//   v0_mask, vm           element mask and unmasked flag
//   vta, vma              agnostic policy bits
//   sew, vl, vstart       element width, active length, start index
//   vd_addr               destination register index
//   wb_valid / wb_ready   VRF write handshake
//   wb_data, wb_be        merged data and byte enables
//   wb_addr               destination register index
//   busy                  FIFO holds at least one entry
module vector_bitwise_wb_stage
    import vec_wb_pkg::*;
#(
    parameter int VLEN = `MAX_VLEN,
    parameter int VL_W = $clog2(VLEN/8) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VLEN-1:0]   bw_result,
    input  logic [VLEN-1:0]   old_vd,
    input  logic [VLEN/8-1:0] v0_mask,
    input  logic              vm,
    input  logic              vta,
    input  logic              vma,
    input  logic [1:0]        sew,
    input  logic [VL_W-1:0]   vl,
    input  logic [VL_W-1:0]   vstart,
    input  logic [4:0]        vd_addr,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [VLEN-1:0]   wb_data,
    output logic [VLEN/8-1:0] wb_be,
    output logic [4:0]        wb_addr,
    output logic              busy
);

    logic [VLEN-1:0]   m_data;
    logic [VLEN/8-1:0] m_be;
    wb_entry_t         new_entry;
    wb_entry_t         mem [0:1];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              push;
    logic              pop;

    vec_wb_merge #(
        .VLEN (VLEN),
        .VL_W (VL_W)
    ) u_merge (
        .bw_result   (bw_result),
        .old_vd      (old_vd),
        .v0_mask     (v0_mask),
        .vm          (vm),
        .vta         (vta),
        .vma         (vma),
        .sew         (sew),
        .vl          (vl),
        .vstart      (vstart),
        .merged_data (m_data),
        .merged_be   (m_be)
    );

    assign new_entry = '{data: m_data, be: m_be, addr: vd_addr};

    // Ready depends on registered count only, so a full FIFO stalls even on a pop cycle.
    assign in_ready = (count != 2'd2);
    assign wb_valid = (count != 2'd0);
    assign busy     = wb_valid;
    assign push     = in_valid && in_ready;
    assign pop      = wb_valid && wb_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    // Outputs read straight from the head register; zeroed while empty.
    assign wb_data = wb_valid ? mem[rd_ptr].data : '0;
    assign wb_be   = wb_valid ? mem[rd_ptr].be   : '0;
    assign wb_addr = wb_valid ? mem[rd_ptr].addr : '0;

endmodule

// File: tb/tb_vector_bitwise_wb_stage.sv
// tb/tb_vector_bitwise_wb_stage.sv - self-checking bench for vector_bitwise_wb_stage
module tb_vector_bitwise_wb_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] bw_result;
    logic [511:0] old_vd;
    logic [63:0]  v0_mask;
    logic         vm, vta, vma;
    logic [1:0]   sew;
    logic [6:0]   vl, vstart;
    logic [4:0]   vd_addr;
    logic         wb_valid;
    logic         wb_ready;
    logic [511:0] wb_data;
    logic [63:0]  wb_be;
    logic [4:0]   wb_addr;
    logic         busy;

    int vectors = 0;
    int errs    = 0;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  be;
        logic [4:0]   a;
    } exp_t;

    exp_t q[$];

    vector_bitwise_wb_stage dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bw_result (bw_result),
        .old_vd    (old_vd),
        .v0_mask   (v0_mask),
        .vm        (vm),
        .vta       (vta),
        .vma       (vma),
        .sew       (sew),
        .vl        (vl),
        .vstart    (vstart),
        .vd_addr   (vd_addr),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_data   (wb_data),
        .wb_be     (wb_be),
        .wb_addr   (wb_addr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk elements, decide each element's fate from the policy rules.
    function automatic exp_t model();
        exp_t r;
        int eb, vlmax, vle, idx;
        eb    = 1 << sew;
        vlmax = 64 / eb;
        vle   = (int'(vl) > vlmax) ? vlmax : int'(vl);
        r.d   = old_vd;
        r.be  = '0;
        r.a   = vd_addr;
        for (int e = 0; e < vlmax; e++) begin
            bit wr, ones;
            wr = 0;
            ones = 0;
            if (e < int'(vstart)) begin
                wr = 0;
            end else if (e >= vle) begin
`ifdef VEC_WB_AGNOSTIC_ONES_EN
                if (vta) begin wr = 1; ones = 1; end
`endif
            end else if (!vm && !v0_mask[e]) begin
`ifdef VEC_WB_AGNOSTIC_ONES_EN
                if (vma) begin wr = 1; ones = 1; end
`endif
            end else begin
                wr = 1;
            end
            if (wr) begin
                for (int k = 0; k < eb; k++) begin
                    idx = e * eb + k;
                    r.d[8*idx +: 8] = ones ? 8'hFF : bw_result[8*idx +: 8];
                    r.be[idx] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    // Check outputs against the model queue, then advance one clock.
    task automatic step();
        bit   pu, po;
        exp_t e;
        chk("in_ready", 512'(in_ready), 512'(q.size() < 2));
        chk("wb_valid", 512'(wb_valid), 512'(q.size() != 0));
        chk("busy",     512'(busy),     512'(q.size() != 0));
        if (q.size() != 0) begin
            chk("wb_data", wb_data, q[0].d);
            chk("wb_be",   512'(wb_be),   512'(q[0].be));
            chk("wb_addr", 512'(wb_addr), 512'(q[0].a));
        end
        po = (q.size() != 0) && wb_ready;
        pu = in_valid && (q.size() < 2);
        e  = model();
        @(posedge clk);
        #1;
        if (po) void'(q.pop_front());
        if (pu) q.push_back(e);
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic defaults();
        bw_result = rand512();
        old_vd    = rand512();
        v0_mask   = {$urandom, $urandom};
        vm = 1'b1; vta = 1'b0; vma = 1'b0;
        sew = 2'd0; vl = 7'd64; vstart = 7'd0;
        vd_addr = 5'($urandom);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; wb_ready = 1'b1;
        defaults();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_wb_valid", 512'(wb_valid), 512'(0));
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        chk("rst_busy",     512'(busy),     512'(0));
        chk("rst_wb_data",  wb_data,        512'(0));
        chk("rst_wb_be",    512'(wb_be),    512'(0));
        chk("rst_wb_addr",  512'(wb_addr),  512'(0));

        // T1: full-length byte elements
        defaults();
        bw_result = {64{8'hAA}}; old_vd = '0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_data", wb_data, {64{8'hAA}});
        chk("t1_be",   512'(wb_be), 512'({64{1'b1}}));
        step();

        // T2: 32-bit elements, vstart=2, vl=5
        defaults();
        sew = 2'd2; vl = 7'd5; vstart = 7'd2;
        bw_result = {64{8'h11}}; old_vd = {64{8'hFF}};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t2_be", 512'(wb_be), 512'(64'h0000_0000_000F_FF00));
        step();

        // T3: 16-bit masked, v0=0101, vl=4
        defaults();
        sew = 2'd1; vm = 1'b0; v0_mask = 64'h5; vl = 7'd4; vma = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t3_be", 512'(wb_be), 512'(64'h33));
        step();

        // T5a: vl=0 still issues an entry, nothing enabled
        defaults();
        vl = 7'd0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t5_be",   512'(wb_be), 512'(0));
        chk("t5_data", wb_data, old_vd);
        step();

        // T6: 64-bit elements, vl=3, tail agnostic
        defaults();
        sew = 2'd3; vl = 7'd3; vta = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
`ifdef VEC_WB_AGNOSTIC_ONES_EN
        chk("t6_be",   512'(wb_be), 512'({64{1'b1}}));
        chk("t6_tail", 512'(wb_data[511:192]), 512'({320{1'b1}}));
`else
        chk("t6_be",   512'(wb_be), 512'(64'hFF_FFFF));
        chk("t6_tail", 512'(wb_data[511:192]), 512'(old_vd[511:192]));
`endif
        step();

        // T4: stalled sink, three back-to-back offers, then drain in order
        wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            defaults();
            in_valid = 1'b1;
            step();
        end
        chk("t4_full", 512'(in_ready), 512'(0));
        in_valid = 1'b0;
        wb_ready = 1'b1;
        repeat (3) step();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            bw_result = rand512();
            old_vd    = rand512();
            v0_mask   = {$urandom, $urandom};
            vm  = 1'($urandom);
            vta = 1'($urandom);
            vma = 1'($urandom);
            sew = 2'($urandom);
            vl  = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'($urandom_range(0, 64 >> sew));
            vstart = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 70)) : 7'd0;
            vd_addr  = 5'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            wb_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        in_valid = 1'b0;
        wb_ready = 1'b1;
        repeat (3) step();

        // T5b: reset with two entries queued discards them
        wb_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            defaults();
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("t5_two_queued", 512'(busy), 512'(1));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        chk("t5_rst_wb_valid", 512'(wb_valid), 512'(0));
        chk("t5_rst_in_ready", 512'(in_ready), 512'(1));
        wb_ready = 1'b1;
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
